gnrl_fifo: RTL and testbench
============================

Name: gnrl_fifo

Overview:
- Parameterised synchronous FIFO with valid/ready handshakes on both sides.
- Sits between pipeline stages of the core (e.g. IFU→EXU instruction queue, LSU request buffer). It sits downstream of the general flop library and consumes it: pointer and count state are built from reset flops, and storage from load-enable flops.
- Decouples producer and consumer timing. It has no combinational path from output to input (ready is never a function of o_rdy).

Parameters:
- DP, 4, depth in entries; power of two, ≥2.
- DW, 32, data width in bits.
- AW, $clog2(DP), derived; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all entries (pipeline flush).
- i_vld  in  1  producer has data.
- i_rdy  out  1  FIFO can accept (not full).
- i_dat  in  DW  write data.
- o_vld  out  1  FIFO holds data (not empty).
- o_rdy  in  1  consumer accepts.
- o_dat  out  DW  head-of-queue data.
- cnt  out  AW+1  current occupancy, 0..DP.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - wptr=0, rptr=0, cnt=0.
  - o_vld=0, i_rdy=1.
  - Storage is not reset; o_dat is don't-care while o_vld=0.
- Pointers are AW+1 bits (extra wrap bit).
  - empty = (wptr==rptr).
  - full = (wptr[AW-1:0]==rptr[AW-1:0]) && (wptr[AW]!=rptr[AW]).
  - Pointers increment modulo 2^(AW+1); the natural wrap of the index field addresses the entry.
- i_rdy = !full. o_vld = !empty. Both are decoded from registered state only.
- push = i_vld & i_rdy; on push, mem[wptr[AW-1:0]] <= i_dat and wptr increments.
- pop = o_vld & o_rdy; on pop, rptr increments.
- o_dat = mem[rptr[AW-1:0]], a combinational read of registered storage.
- Latency: data pushed in cycle N appears on o_dat with o_vld=1 in cycle N+1. There is no same-cycle bypass when empty.
- Push and pop in the same cycle (FIFO neither empty nor full): both occur and cnt is unchanged.
- When full, i_rdy=0, so a push in the same cycle as a pop is not accepted. Ready frees in the following cycle; there is no pass-through.
- When empty, o_vld=0; a pop is impossible, and a push only fills the FIFO.
- cnt: +1 on push only, −1 on pop only, unchanged otherwise.
  - cnt == wptr − rptr at all times.
  - cnt never exceeds DP and never underflows.
- flush (sync) has priority over push and pop in the same cycle.
  - The next state is wptr=rptr=0, cnt=0, o_vld=0, i_rdy=1.
  - The push in a flush cycle is discarded.
- Reset mid-operation: all state returns immediately (asynchronously) to the reset values. Content is lost.
- Producer protocol: once i_vld=1 with i_rdy=0, the producer holds i_vld and i_dat until accepted.
- Consumer protocol: o_dat is stable while o_vld=1 and o_rdy=0.
- No X propagation: o_vld, i_rdy and cnt must be known whenever rst_n has been asserted once.

Test Plan:
- Reset then idle → o_vld=0, i_rdy=1, cnt=0. After 5 idle cycles: no change.
- DP=4, push 0x11,0x22,0x33,0x44 on consecutive cycles with o_rdy=0 → cnt goes 1,2,3,4. i_rdy=0 after the 4th push; a 5th push of 0x55 held by the producer is not accepted. o_dat=0x11 throughout.
- From full, o_rdy=1 with i_vld=1 (data 0x55) → cycle 1: pop 0x11, push blocked. Cycle 2: i_rdy=1, push 0x55 and pop 0x22. Drain order thereafter: 0x33, 0x44, 0x55.
- Continuous streaming: i_vld=o_rdy=1 for 20 cycles with incrementing data 0..19 → after the first-cycle latency, cnt stays at 1, output sequence equals input order, and pointers wrap past DP with no loss or duplication.
- With cnt=3, assert flush together with push of 0xAA and o_rdy=1 → next cycle: cnt=0, o_vld=0, i_rdy=1. 0xAA never appears on the output.
- With cnt=2, assert rst_n=0 asynchronously mid-cycle → o_vld and cnt go to 0 before the next edge. After release, the first push of 0x5A is output in the next cycle.

Source files
------------

// File: rtl/gnrl_fifo.sv
// rtl/gnrl_fifo.sv - parameterised synchronous valid/ready FIFO built on the general flop library

// Reset flop with load enable: pointer and occupancy state.
module gnrl_dfflr #(
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lden_i,
   input  logic [DW-1:0] dnxt_i,
   output logic [DW-1:0] qout_o
);

   logic [DW-1:0] qout_q;

   // Asynchronous clear, load only when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qout_q <= '0;
      end else if (lden_i) begin
         qout_q <= dnxt_i;
      end
   end

   assign qout_o = qout_q;

endmodule

// Load-enable flop without reset: storage entries, content is don't-care until written.
module gnrl_dffl #(
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          lden_i,
   input  logic [DW-1:0] dnxt_i,
   output logic [DW-1:0] qout_o
);

   logic [DW-1:0] qout_q;

   // Capture new data only when enabled.
   always_ff @(posedge clk) begin
      if (lden_i) begin
         qout_q <= dnxt_i;
      end
   end

   assign qout_o = qout_q;

endmodule

// FIFO top: pointers carry an extra wrap bit so full and empty are distinguishable.
module gnrl_fifo #(
   parameter int DP = 4,
   parameter int DW = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     i_vld,
   output logic                     i_rdy,
   input  logic [DW-1:0]            i_dat,
   output logic                     o_vld,
   input  logic                     o_rdy,
   output logic [DW-1:0]            o_dat,
   output logic [$clog2(DP):0]      cnt
);

   localparam int AW = $clog2(DP);

   logic [AW:0]   wptr_q;
   logic [AW:0]   wptr_d;
   logic [AW:0]   rptr_q;
   logic [AW:0]   rptr_d;
   logic [AW:0]   cnt_q;
   logic [AW:0]   cnt_d;
   logic          ptr_en;
   logic          cnt_en;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [DW-1:0] mem_q [DP];

   // Status decoded from registered pointers only, so ready never depends on o_rdy.
   always_comb begin
      empty = (wptr_q == rptr_q);
      full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
      i_rdy = !full;
      o_vld = !empty;
      push  = i_vld & i_rdy;
      pop   = o_vld & o_rdy;
   end

   // Next pointer and occupancy; flush overrides any push or pop in the same cycle.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      ptr_en = flush | push | pop;
      cnt_en = flush | (push ^ pop);
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) begin
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
         end
         if (pop) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
         end
         if (push && !pop) begin
            cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
         end else if (pop && !push) begin
            cnt_d = cnt_q - {{AW{1'b0}}, 1'b1};
         end
      end
   end

   gnrl_dfflr #(.DW(AW+1)) u_wptr (
      .clk    (clk),
      .rst_n  (rst_n),
      .lden_i (ptr_en),
      .dnxt_i (wptr_d),
      .qout_o (wptr_q)
   );

   gnrl_dfflr #(.DW(AW+1)) u_rptr (
      .clk    (clk),
      .rst_n  (rst_n),
      .lden_i (ptr_en),
      .dnxt_i (rptr_d),
      .qout_o (rptr_q)
   );

   gnrl_dfflr #(.DW(AW+1)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .lden_i (cnt_en),
      .dnxt_i (cnt_d),
      .qout_o (cnt_q)
   );

   // One load-enable flop per entry; a push during flush is discarded.
   for (genvar gi = 0; gi < DP; gi++) begin : g_mem
      logic wen;
      assign wen = push & ~flush & (wptr_q[AW-1:0] == gi[AW-1:0]);
      gnrl_dffl #(.DW(DW)) u_ent (
         .clk    (clk),
         .lden_i (wen),
         .dnxt_i (i_dat),
         .qout_o (mem_q[gi])
      );
   end

   assign o_dat = mem_q[rptr_q[AW-1:0]];
   assign cnt   = cnt_q;

endmodule

// File: tb/tb_gnrl_fifo.sv
// tb/tb_gnrl_fifo.sv - self-checking bench for gnrl_fifo: vector table, corner sequences, randomized model

module tb_gnrl_fifo;

   localparam int DP = 4;
   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          i_vld;
   logic          i_rdy;
   logic [DW-1:0] i_dat;
   logic          o_vld;
   logic          o_rdy;
   logic [DW-1:0] o_dat;
   logic [2:0]    cnt;

   int n_vec;
   int n_err;

   typedef struct {
      logic          fl;
      logic          vld;
      logic [DW-1:0] dat;
      logic          rdy;
      logic          e_ovld;
      logic          e_irdy;
      logic [2:0]    e_cnt;
      logic [DW-1:0] e_dat;
      logic          chk_dat;
   } vec_t;

   vec_t tbl[$];

   gnrl_fifo #(.DP(DP), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .i_vld (i_vld),
      .i_rdy (i_rdy),
      .i_dat (i_dat),
      .o_vld (o_vld),
      .o_rdy (o_rdy),
      .o_dat (o_dat),
      .cnt   (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic fl, input logic vld, input logic [DW-1:0] dat, input logic rdy,
                               input logic e_ovld, input logic e_irdy, input logic [2:0] e_cnt,
                               input logic [DW-1:0] e_dat, input logic chk_dat);
      vec_t v;
      v.fl = fl; v.vld = vld; v.dat = dat; v.rdy = rdy;
      v.e_ovld = e_ovld; v.e_irdy = e_irdy; v.e_cnt = e_cnt; v.e_dat = e_dat; v.chk_dat = chk_dat;
      return v;
   endfunction

   // Expectations describe outputs before the edge that consumes the inputs.
   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      flush = v.fl; i_vld = v.vld; i_dat = v.dat; o_rdy = v.rdy;
      #1;
      chk($sformatf("v%0d o_vld", idx), {31'd0, o_vld}, {31'd0, v.e_ovld});
      chk($sformatf("v%0d i_rdy", idx), {31'd0, i_rdy}, {31'd0, v.e_irdy});
      chk($sformatf("v%0d cnt", idx), {29'd0, cnt}, {29'd0, v.e_cnt});
      if (v.chk_dat) chk($sformatf("v%0d o_dat", idx), o_dat, v.e_dat);
   endtask

   logic [DW-1:0] q[$];
   bit            hold;
   bit            m_push;
   bit            m_pop;
   bit            m_full;

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; flush = 1'b0; i_vld = 1'b0; i_dat = '0; o_rdy = 1'b0;
      #12;
      chk("reset o_vld", {31'd0, o_vld}, 32'd0);
      chk("reset i_rdy", {31'd0, i_rdy}, 32'd1);
      chk("reset cnt", {29'd0, cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle, fill to full, blocked push, pop-from-full, drain, then flush with push.
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h11, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h22, 0, 1, 1, 1, 32'h11, 1));
      tbl.push_back(mk(0, 1, 32'h33, 0, 1, 1, 2, 32'h11, 1));
      tbl.push_back(mk(0, 1, 32'h44, 0, 1, 1, 3, 32'h11, 1));
      tbl.push_back(mk(0, 1, 32'h55, 0, 1, 0, 4, 32'h11, 1));
      tbl.push_back(mk(0, 1, 32'h55, 0, 1, 0, 4, 32'h11, 1));
      tbl.push_back(mk(0, 1, 32'h55, 1, 1, 0, 4, 32'h11, 1));
      tbl.push_back(mk(0, 1, 32'h55, 1, 1, 1, 3, 32'h22, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 3, 32'h33, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 2, 32'h44, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h55, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'hA1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'hA2, 0, 1, 1, 1, 32'hA1, 1));
      tbl.push_back(mk(0, 1, 32'hA3, 0, 1, 1, 2, 32'hA1, 1));
      tbl.push_back(mk(1, 1, 32'hAA, 1, 1, 1, 3, 32'hA1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
      foreach (tbl[i]) apply(tbl[i], i);

      // Streaming: one push and one pop per cycle across several pointer wraps.
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         flush = 1'b0; i_vld = 1'b1; i_dat = k; o_rdy = 1'b1;
         #1;
         if (k == 0) begin
            chk("stream first o_vld", {31'd0, o_vld}, 32'd0);
         end else begin
            chk($sformatf("stream%0d cnt", k), {29'd0, cnt}, 32'd1);
            chk($sformatf("stream%0d o_dat", k), o_dat, k - 1);
         end
      end
      @(negedge clk);
      i_vld = 1'b0;
      #1;
      chk("stream last o_dat", o_dat, 32'd19);
      @(negedge clk);
      o_rdy = 1'b0;
      #1;
      chk("stream drained o_vld", {31'd0, o_vld}, 32'd0);

      // Asynchronous reset with two entries held.
      apply(mk(0, 1, 32'hB1, 0, 0, 1, 0, 0, 0), 100);
      apply(mk(0, 1, 32'hB2, 0, 1, 1, 1, 32'hB1, 1), 101);
      apply(mk(0, 0, 0, 0, 1, 1, 2, 32'hB1, 1), 102);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async rst o_vld", {31'd0, o_vld}, 32'd0);
      chk("async rst cnt", {29'd0, cnt}, 32'd0);
      chk("async rst i_rdy", {31'd0, i_rdy}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1; i_vld = 1'b1; i_dat = 32'h5A;
      @(negedge clk);
      i_vld = 1'b0;
      #1;
      chk("post rst o_vld", {31'd0, o_vld}, 32'd1);
      chk("post rst o_dat", o_dat, 32'h5A);
      chk("post rst cnt", {29'd0, cnt}, 32'd1);
      apply(mk(1, 0, 0, 0, 1, 1, 1, 32'h5A, 1), 103);

      // Randomized traffic against a queue model of the FIFO contents.
      q.delete();
      hold = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!hold) begin
            i_vld = ($urandom_range(0, 3) != 0);
            i_dat = $urandom;
         end
         o_rdy = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 40) == 0);
         #1;
         chk("rnd o_vld", {31'd0, o_vld}, {31'd0, q.size() != 0});
         chk("rnd i_rdy", {31'd0, i_rdy}, {31'd0, q.size() < DP});
         chk("rnd cnt", {29'd0, cnt}, q.size());
         if (q.size() != 0) chk("rnd o_dat", o_dat, q[0]);
         m_full = (q.size() == DP);
         m_push = i_vld && !m_full;
         m_pop  = o_rdy && (q.size() != 0);
         hold   = i_vld && m_full && !flush;
         if (flush) begin
            q.delete();
         end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(i_dat);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
